// File: rtl/mux_arbiter2.sv
// -----------------------------------------------------------------------------
// mux_arbiter2
//
// Two-requester arbiter that owns the select of a shared 2:1 single-bit path.
// Ownership is granted round-robin with a bounded hold time: an owner keeps
// the grant for at most MAX_HOLD consecutive cycles while the other side is
// waiting.  An uncontested owner keeps the grant indefinitely.  The granted
// requester's data bit is gated onto Y.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles an owner keeps the grant under
//             contention (1..255)
//   CNT_W     width of the hold counter, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   REQ_A      level request from requester A
//   REQ_B      level request from requester B
//   DIN_A      data bit from requester A
//   DIN_B      data bit from requester B
//   GNT_A      registered grant to A
//   GNT_B      registered grant to B
//   SEL        registered mux select, 1 = A path, 0 = B path
//   Y          shared output, (GNT_A & DIN_A) | (GNT_B & DIN_B)
//   BUSY       GNT_A | GNT_B
//   dbg_state  current FSM state (0 = IDLE, 1 = OWN_A, 2 = OWN_B)
//
// Handshake: REQ_x is a level; holding it high means "access wanted".  GNT_x
// rises one edge after the request is sampled and stays high for as long as
// the requester owns the path.  A request dropped before it is granted leaves
// no trace.
//
// Optional build macro
//   MUX_ARB_SYNC_EN  when defined, REQ_A/REQ_B each pass through a 2-flop
//                    synchronizer (reset to 0) before the FSM, adding two
//                    cycles to both grant and release latency.  When
//                    undefined, requests must be synchronous to clk.
// -----------------------------------------------------------------------------
module mux_arbiter2 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic       DIN_A,
  input  logic       DIN_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       SEL,
  output logic       Y,
  output logic       BUSY,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  // Counter value at which a contested owner must hand over; also the
  // saturation point for an uncontested owner.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             last_a;       // 1 = A was the most recent owner
  logic             last_a_nxt;
  logic             take_a;
  logic             take_b;
  logic             req_a;        // request as seen by the FSM
  logic             req_b;

  // ---------------------------------------------------------------------------
  // Request conditioning
  // ---------------------------------------------------------------------------
`ifdef MUX_ARB_SYNC_EN
  logic req_a_s1;
  logic req_a_s2;
  logic req_b_s1;
  logic req_b_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_a_s1 <= 1'b0;
      req_a_s2 <= 1'b0;
      req_b_s1 <= 1'b0;
      req_b_s2 <= 1'b0;
    end else begin
      req_a_s1 <= REQ_A;
      req_a_s2 <= req_a_s1;
      req_b_s1 <= REQ_B;
      req_b_s2 <= req_b_s1;
    end
  end

  assign req_a = req_a_s2;
  assign req_b = req_b_s2;
`else
  assign req_a = REQ_A;
  assign req_b = REQ_B;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    last_a_nxt   = last_a;
    take_a       = 1'b0;
    take_b       = 1'b0;

    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          // Tie: the side that did not own last goes first.
          if (last_a) take_b = 1'b1;
          else        take_a = 1'b1;
        end else if (req_a) begin
          take_a = 1'b1;
        end else if (req_b) begin
          take_b = 1'b1;
        end
      end

      OWN_A: begin
        if (!req_a) begin
          // Release: hand straight to a waiting B, no idle gap.
          if (req_b) take_b = 1'b1;
          else       state_nxt = IDLE;
        end else if (req_b && (hold_cnt == HOLD_LAST)) begin
          take_b = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      OWN_B: begin
        if (!req_b) begin
          if (req_a) take_a = 1'b1;
          else       state_nxt = IDLE;
        end else if (req_a && (hold_cnt == HOLD_LAST)) begin
          take_a = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Every entry into an ownership state restarts the hold count and
    // records the new owner for the next tie-break.
    if (take_a) begin
      state_nxt    = OWN_A;
      hold_cnt_nxt = '0;
      last_a_nxt   = 1'b1;
    end else if (take_b) begin
      state_nxt    = OWN_B;
      hold_cnt_nxt = '0;
      last_a_nxt   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_a   <= 1'b0;
      GNT_A    <= 1'b0;
      GNT_B    <= 1'b0;
      SEL      <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      last_a   <= last_a_nxt;
      // Grants are registered from the next state so the old grant falls
      // and the new one rises on the same edge.
      GNT_A    <= (state_nxt == OWN_A);
      GNT_B    <= (state_nxt == OWN_B);
      SEL      <= (state_nxt == OWN_A);
    end
  end

  assign Y         = (GNT_A & DIN_A) | (GNT_B & DIN_B);
  assign BUSY      = GNT_A | GNT_B;
  assign dbg_state = state;

endmodule
